// File: rtl/msg_frame_link.sv
// msg_frame_link: byte-serial framed link with an RX frame assembler (idle timeout) and a TX serializer FSM.
// Define FRAME_CHECKSUM_EN to append an XOR checksum byte to every frame on both RX and TX.
module msg_frame_link #(
  parameter int unsigned NBYTES      = 10,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                msclk,
  input  logic                rst,
  input  logic [7:0]          rx_byte,
  input  logic                rx_strobe,
  output logic [8*NBYTES-1:0] odata,
  output logic                datavalid,
  input  logic [8*NBYTES-1:0] idata,
  input  logic                senddata,
  output logic                busy,
  output logic [7:0]          tx_byte,
  output logic                tx_strobe,
  input  logic                tx_ready,
  output logic                err_timeout,
  output logic                err_overrun,
  output logic                err_chk
);
  localparam int unsigned PW = 8*NBYTES;
`ifdef FRAME_CHECKSUM_EN
  localparam int unsigned FLEN = NBYTES + 1;
`else
  localparam int unsigned FLEN = NBYTES;
`endif
  localparam int unsigned CW = $clog2(FLEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

`ifdef FRAME_CHECKSUM_EN
  function automatic logic [7:0] xor_bytes(input logic [PW-1:0] v);
    logic [7:0] x;
    x = '0;
    for (int unsigned i = 0; i < NBYTES; i++) x ^= v[8*i +: 8];
    return x;
  endfunction
  logic err_chk_q;
  assign err_chk = err_chk_q;
`else
  assign err_chk = 1'b0;
`endif

  // ---------------- RX path ----------------
  logic [PW-1:0] shadow, shadow_nxt;
  logic [CW-1:0] rx_cnt;
  logic [TW-1:0] timer;
  logic          rx_last;

  assign rx_last = rx_strobe && (rx_cnt == CW'(FLEN - 1));

  // Payload byte k lands MSB-first; a trailing checksum byte is never stored
  always_comb begin
    shadow_nxt = shadow;
    if (rx_strobe && (32'(rx_cnt) < NBYTES))
      shadow_nxt[8*(NBYTES - 1 - 32'(rx_cnt)) +: 8] = rx_byte;
  end

  always_ff @(posedge msclk or posedge rst) begin
    if (rst) begin
      shadow      <= '0;
      odata       <= '0;
      rx_cnt      <= '0;
      timer       <= '0;
      datavalid   <= 1'b0;
      err_timeout <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      err_chk_q   <= 1'b0;
`endif
    end else begin
      datavalid   <= 1'b0;
      err_timeout <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      err_chk_q   <= 1'b0;
`endif
      shadow <= shadow_nxt;
      if (rx_strobe) begin
        timer <= '0;
        if (rx_last) begin
          rx_cnt <= '0;
`ifdef FRAME_CHECKSUM_EN
          if (rx_byte == xor_bytes(shadow)) begin
            odata     <= shadow;
            datavalid <= 1'b1;
          end else begin
            err_chk_q <= 1'b1;
          end
`else
          odata     <= shadow_nxt;
          datavalid <= 1'b1;
`endif
        end else begin
          rx_cnt <= rx_cnt + CW'(1);
        end
      end else if (rx_cnt != '0) begin
        // Timer only runs mid-frame; a strobe on the expiry cycle takes the branch above
        if (timer == TW'(TIMEOUT_CYC - 1)) begin
          rx_cnt      <= '0;
          timer       <= '0;
          err_timeout <= 1'b1;
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end
  end

  // ---------------- TX path ----------------
  typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_t;

  tx_state_t     state, state_nxt;
  logic [PW-1:0] tx_shift, tx_shift_nxt;
  logic [CW-1:0] tx_idx, tx_idx_nxt;
  logic [7:0]    tx_byte_nxt;
  logic          busy_nxt, tx_strobe_nxt, err_overrun_nxt;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]    tx_chk, tx_chk_nxt;
`endif

  always_ff @(posedge msclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tx_shift    <= '0;
      tx_idx      <= '0;
      busy        <= 1'b0;
      tx_byte     <= '0;
      tx_strobe   <= 1'b0;
      err_overrun <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      tx_chk      <= '0;
`endif
    end else begin
      state       <= state_nxt;
      tx_shift    <= tx_shift_nxt;
      tx_idx      <= tx_idx_nxt;
      busy        <= busy_nxt;
      tx_byte     <= tx_byte_nxt;
      tx_strobe   <= tx_strobe_nxt;
      err_overrun <= err_overrun_nxt;
`ifdef FRAME_CHECKSUM_EN
      tx_chk      <= tx_chk_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt       = state;
    tx_shift_nxt    = tx_shift;
    tx_idx_nxt      = tx_idx;
    busy_nxt        = busy;
    tx_byte_nxt     = tx_byte;
    tx_strobe_nxt   = 1'b0;
    err_overrun_nxt = senddata && busy;
`ifdef FRAME_CHECKSUM_EN
    tx_chk_nxt      = tx_chk;
`endif
    unique case (state)
      IDLE: begin
        if (senddata) begin
          tx_shift_nxt = idata;
          tx_idx_nxt   = '0;
          busy_nxt     = 1'b1;
          state_nxt    = SEND;
`ifdef FRAME_CHECKSUM_EN
          tx_chk_nxt   = xor_bytes(idata);
`endif
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_byte_nxt   = tx_shift[PW-1 -: 8];
`ifdef FRAME_CHECKSUM_EN
          if (tx_idx == CW'(NBYTES)) tx_byte_nxt = tx_chk;
`endif
          tx_shift_nxt  = tx_shift << 8;
          tx_strobe_nxt = 1'b1;
          state_nxt     = GAP;
        end
      end
      GAP: begin
        if (tx_idx == CW'(FLEN - 1)) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          tx_idx_nxt = tx_idx + CW'(1);
          state_nxt  = SEND;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_msg_frame_link.sv
// Self-checking bench for msg_frame_link: randomized frames checked against a queue-based frame model.
`timescale 1ns/1ps
module tb_msg_frame_link;
  localparam int unsigned NB = 10;
  localparam int unsigned TO = 40;
  localparam int unsigned PW = 8*NB;

  typedef logic [7:0] bq_t[$];

  logic          msclk, rst;
  logic [7:0]    rx_byte;
  logic          rx_strobe;
  logic [PW-1:0] odata;
  logic          datavalid;
  logic [PW-1:0] idata;
  logic          senddata, busy;
  logic [7:0]    tx_byte;
  logic          tx_strobe, tx_ready;
  logic          err_timeout, err_overrun, err_chk;

  msg_frame_link #(.NBYTES(NB), .TIMEOUT_CYC(TO)) dut (
    .msclk(msclk), .rst(rst), .rx_byte(rx_byte), .rx_strobe(rx_strobe),
    .odata(odata), .datavalid(datavalid), .idata(idata), .senddata(senddata),
    .busy(busy), .tx_byte(tx_byte), .tx_strobe(tx_strobe), .tx_ready(tx_ready),
    .err_timeout(err_timeout), .err_overrun(err_overrun), .err_chk(err_chk)
  );

  initial msclk = 1'b0;
  always #5 msclk = ~msclk;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  logic [PW-1:0] exp_odata = '0;

  // Observation queues filled on the falling edge
  logic [7:0]    txq[$];
  int unsigned   txt[$];
  logic [PW-1:0] dvq[$];
  int n_to = 0, n_ovr = 0, n_chk = 0;

  always @(posedge msclk) cyc <= cyc + 1;
  always @(negedge msclk) begin
    if (tx_strobe) begin txq.push_back(tx_byte); txt.push_back(cyc); end
    if (datavalid) dvq.push_back(odata);
    if (err_timeout) n_to++;
    if (err_overrun) n_ovr++;
    if (err_chk) n_chk++;
  end

  // ---------------- reference model ----------------
  function automatic logic [PW-1:0] pack(input bq_t b);
    logic [PW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(NB); i++) v = (v << 8) | PW'(b[i]);
    return v;
  endfunction

  function automatic bq_t unpack(input logic [PW-1:0] v);
    bq_t q;
    logic [PW-1:0] t;
    for (int k = 0; k < int'(NB); k++) begin
      t = v >> (8*(int'(NB) - 1 - k));
      q.push_back(t[7:0]);
    end
    return q;
  endfunction

  function automatic logic [7:0] xsum(input bq_t b);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < int'(NB); i++) x ^= b[i];
    return x;
  endfunction

  function automatic bq_t frame_of(input bq_t p);
    bq_t f;
    f = p;
`ifdef FRAME_CHECKSUM_EN
    f.push_back(xsum(p));
`endif
    return f;
  endfunction

  function automatic bq_t rand_payload();
    bq_t p;
    for (int i = 0; i < int'(NB); i++) p.push_back(8'($urandom_range(255, 0)));
    return p;
  endfunction

  function automatic bit qeq(input bq_t a, input bq_t b);
    if (a.size() != b.size()) return 1'b0;
    for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge msclk);
    #1;
  endtask

  task automatic rx_send(input logic [7:0] b);
    rx_byte = b;
    rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
  endtask

  task automatic rx_frame(input bq_t f, input int maxgap);
    foreach (f[i]) begin
      rx_send(f[i]);
      repeat ($urandom_range(maxgap, 0)) tick();
    end
  endtask

  task automatic tx_start(input logic [PW-1:0] d);
    idata = d;
    senddata = 1'b1;
    tick();
    senddata = 1'b0;
  endtask

  task automatic wait_tx_idle(input int rand_ready);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      if (rand_ready != 0) tx_ready = 1'($urandom_range(1, 0));
      tick();
      n++;
    end
    tx_ready = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL tx_idle_wait busy=%b after %0d cycles, want 0", busy, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; rx_byte = '0; rx_strobe = 1'b0; idata = '0; senddata = 1'b0; tx_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({odata, datavalid, busy, tx_byte, tx_strobe, err_timeout, err_overrun, err_chk} !== '0) begin
      errors++;
      $display("FAIL reset_held outputs=%h want 0", {odata, datavalid, busy, tx_byte, tx_strobe, err_timeout, err_overrun, err_chk});
    end
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({odata, datavalid, busy, tx_byte, tx_strobe, err_timeout, err_overrun, err_chk} !== '0) begin
      errors++;
      $display("FAIL reset_release outputs=%h want 0", {odata, datavalid, busy, tx_byte, tx_strobe, err_timeout, err_overrun, err_chk});
    end
  endtask

  task automatic test_rx_known();
    bq_t p, f;
    for (int i = 0; i < int'(NB); i++) p.push_back(8'(8'h41 + i));
    f = frame_of(p);
    dvq.delete();
    for (int i = 0; i < f.size() - 1; i++) begin
      rx_send(f[i]);
      if (i == 4) begin
        checks++;
        if (odata !== exp_odata || datavalid !== 1'b0) begin
          errors++;
          $display("FAIL rx_partial_hold odata=%h dv=%b want %h dv=0", odata, datavalid, exp_odata);
        end
      end
    end
    rx_send(f[f.size() - 1]);
    exp_odata = pack(p);
    checks++;
    if (datavalid !== 1'b1 || odata !== exp_odata) begin
      errors++;
      $display("FAIL rx_known dv=%b odata=%h want dv=1 odata=%h", datavalid, odata, exp_odata);
    end
    tick();
    checks++;
    if (datavalid !== 1'b0 || dvq.size() != 1) begin
      errors++;
      $display("FAIL rx_known_pulse dv=%b pulses=%0d want dv=0 pulses=1", datavalid, dvq.size());
    end
  endtask

  task automatic test_rx_random();
    logic [PW-1:0] expv[$];
    bq_t p;
    dvq.delete();
    for (int f = 0; f < 6; f++) begin
      p = rand_payload();
      expv.push_back(pack(p));
      rx_frame(frame_of(p), (f % 2 == 0) ? 0 : 3);
    end
    tick(); tick();
    checks++;
    if (dvq.size() != expv.size()) begin
      errors++;
      $display("FAIL rx_random_count got %0d frames want %0d", dvq.size(), expv.size());
    end
    for (int i = 0; i < expv.size(); i++) begin
      checks++;
      if (i >= dvq.size() || dvq[i] !== expv[i]) begin
        errors++;
        $display("FAIL rx_random_frame%0d got %h want %h", i, (i < dvq.size()) ? dvq[i] : '0, expv[i]);
      end
    end
    exp_odata = expv[$];
  endtask

  task automatic test_timeout();
    bq_t p, f;
    int to0;
    dvq.delete();
    to0 = n_to;
    for (int i = 0; i < 3; i++) rx_send(8'($urandom_range(255, 0)));
    repeat (TO) tick();
    checks++;
    if (err_timeout !== 1'b1 || odata !== exp_odata) begin
      errors++;
      $display("FAIL timeout_expire err_timeout=%b odata=%h want 1 odata=%h", err_timeout, odata, exp_odata);
    end
    tick();
    checks++;
    if (err_timeout !== 1'b0 || n_to != to0 + 1 || dvq.size() != 0) begin
      errors++;
      $display("FAIL timeout_once err_timeout=%b pulses=%0d dv=%0d want 0 1 0", err_timeout, n_to - to0, dvq.size());
    end
    p = rand_payload();
    rx_frame(frame_of(p), 2);
    tick();
    exp_odata = pack(p);
    checks++;
    if (dvq.size() != 1 || odata !== exp_odata) begin
      errors++;
      $display("FAIL timeout_recover frames=%0d odata=%h want 1 %h", dvq.size(), odata, exp_odata);
    end
    // Strobe on exactly the expiry cycle must win; idle with count 0 must never time out
    p = rand_payload();
    f = frame_of(p);
    rx_send(f[0]);
    repeat (TO - 1) tick();
    for (int i = 1; i < f.size(); i++) rx_send(f[i]);
    repeat (2*TO) tick();
    exp_odata = pack(p);
    checks++;
    if (n_to != to0 + 1 || dvq.size() != 2 || odata !== exp_odata) begin
      errors++;
      $display("FAIL timeout_boundary pulses=%0d frames=%0d odata=%h want 1 2 %h", n_to - to0, dvq.size(), odata, exp_odata);
    end
  endtask

  task automatic test_tx_known();
    bq_t expb;
    int hold_bad, gap_bad;
    logic [PW-1:0] d;
    d = 80'h00112233445566778899;
    expb = frame_of(unpack(d));
    txq.delete(); txt.delete();
    hold_bad = 0;
    tx_ready = 1'b1;
    tx_start(d);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL tx_busy_rise busy=%b want 1", busy);
    end
    for (int n = 0; n < 200 && busy === 1'b1; n++) begin
      tick();
      if (tx_strobe !== 1'b1 && txq.size() > 0 && tx_byte !== txq[$]) hold_bad++;
    end
    repeat (5) tick();
    checks++;
    if (!qeq(txq, expb) || busy !== 1'b0) begin
      errors++;
      $display("FAIL tx_known bytes=%0d first=%h last=%h busy=%b want %0d bytes %h..%h busy=0",
               txq.size(), (txq.size() > 0) ? txq[0] : 8'h0, (txq.size() > 0) ? txq[$] : 8'h0, busy,
               expb.size(), expb[0], expb[$]);
    end
    gap_bad = 0;
    for (int i = 1; i < txt.size(); i++) if (txt[i] - txt[i-1] != 2) gap_bad++;
    checks++;
    if (gap_bad != 0 || hold_bad != 0) begin
      errors++;
      $display("FAIL tx_spacing_hold bad_gaps=%0d hold_violations=%0d want 0 0", gap_bad, hold_bad);
    end
  endtask

  task automatic test_overrun();
    logic [PW-1:0] a, b;
    bq_t expb;
    int sz;
    a = {$urandom, $urandom, 16'($urandom)};
    b = ~a;
    expb = frame_of(unpack(a));
    txq.delete(); txt.delete();
    tx_ready = 1'b1;
    tx_start(a);
    tick(); tick(); tick();
    tx_start(b);
    checks++;
    if (err_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_pulse err_overrun=%b want 1", err_overrun);
    end
    tick();
    checks++;
    if (err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_once err_overrun=%b want 0", err_overrun);
    end
    tx_ready = 1'b0;
    tick();
    sz = txq.size();
    repeat (20) tick();
    checks++;
    if (txq.size() != sz || busy !== 1'b1 || tx_strobe !== 1'b0) begin
      errors++;
      $display("FAIL tx_ready_stall strobes=%0d busy=%b want 0 busy=1", txq.size() - sz, busy);
    end
    tx_ready = 1'b1;
    wait_tx_idle(0);
    checks++;
    if (!qeq(txq, expb)) begin
      errors++;
      $display("FAIL overrun_frame bytes=%0d last=%h want %0d last=%h", txq.size(),
               (txq.size() > 0) ? txq[$] : 8'h0, expb.size(), expb[$]);
    end
  endtask

  task automatic test_concurrent();
    bq_t prx, btx;
    logic [PW-1:0] d;
    int to0;
    prx = rand_payload();
    btx = rand_payload();
    d = pack(btx);
    txq.delete(); txt.delete(); dvq.delete();
    to0 = n_to;
    fork
      rx_frame(frame_of(prx), 2);
      begin
        tx_start(d);
        wait_tx_idle(1);
      end
    join
    tick(); tick();
    exp_odata = pack(prx);
    checks++;
    if (dvq.size() != 1 || odata !== exp_odata || n_to != to0) begin
      errors++;
      $display("FAIL concurrent_rx frames=%0d odata=%h want 1 %h", dvq.size(), odata, exp_odata);
    end
    checks++;
    if (!qeq(txq, frame_of(btx))) begin
      errors++;
      $display("FAIL concurrent_tx bytes=%0d want %0d", txq.size(), frame_of(btx).size());
    end
  endtask

`ifdef FRAME_CHECKSUM_EN
  task automatic test_checksum();
    bq_t p, f;
    int c0;
    for (int i = 0; i < int'(NB); i++) p.push_back(8'(i + 1));
    f = p;
    f.push_back(8'h0B);
    dvq.delete();
    rx_frame(f, 0);
    exp_odata = pack(p);
    checks++;
    if (datavalid !== 1'b1 || odata !== exp_odata || err_chk !== 1'b0) begin
      errors++;
      $display("FAIL chk_good dv=%b err_chk=%b odata=%h want 1 0 %h", datavalid, err_chk, odata, exp_odata);
    end
    c0 = n_chk;
    f[NB] = 8'h00;
    for (int i = 0; i < int'(NB); i++) f[i] = 8'(8'hA0 + i);
    rx_frame(f, 0);
    checks++;
    if (err_chk !== 1'b1 || datavalid !== 1'b0 || odata !== exp_odata) begin
      errors++;
      $display("FAIL chk_bad err_chk=%b dv=%b odata=%h want 1 0 %h", err_chk, datavalid, odata, exp_odata);
    end
    txq.delete(); txt.delete();
    tx_start(pack(p));
    wait_tx_idle(0);
    checks++;
    if (txq.size() != NB + 1 || txq[$] !== 8'h0B || n_chk != c0 + 1) begin
      errors++;
      $display("FAIL chk_tx bytes=%0d last=%h want %0d last=0b", txq.size(), (txq.size() > 0) ? txq[$] : 8'h0, NB + 1);
    end
  endtask
`endif

  task automatic test_reset_mid();
    bq_t p;
    tx_ready = 1'b1;
    tx_start({$urandom | 32'h1, $urandom, 16'($urandom)});
    for (int i = 0; i < 5; i++) rx_send(8'($urandom_range(255, 1)));
    rst = 1'b1;
    #1;
    checks++;
    if ({odata, datavalid, busy, tx_byte, tx_strobe, err_timeout, err_overrun, err_chk} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs=%h want 0", {odata, datavalid, busy, tx_byte, tx_strobe, err_timeout, err_overrun, err_chk});
    end
    tick(); tick();
    rst = 1'b0;
    exp_odata = '0;
    txq.delete(); txt.delete(); dvq.delete();
    repeat (10) tick();
    checks++;
    if (txq.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_tx_abort strobes=%0d busy=%b want 0 0", txq.size(), busy);
    end
    p = rand_payload();
    rx_frame(frame_of(p), 1);
    tick();
    exp_odata = pack(p);
    checks++;
    if (dvq.size() != 1 || odata !== exp_odata) begin
      errors++;
      $display("FAIL reset_fresh_frame frames=%0d odata=%h want 1 %h", dvq.size(), odata, exp_odata);
    end
  endtask

  initial begin
    test_reset();
    test_rx_known();
    test_rx_random();
    test_timeout();
    test_tx_known();
    test_overrun();
    test_concurrent();
`ifdef FRAME_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
